// File: rtl/xg_mac_tx.sv
// xg_mac_tx: AXI-Stream to XGMII (64-bit, one column per clock) transmit MAC.
// Wraps each frame in a start column (preamble + SFD), appends a CRC-32 FCS,
// terminates with /T/ (or /E/ /T/ on an errored or underrun frame), and
// enforces IFG_CYCLES idle columns after the column holding /T/.
//
// Parameters:
//   IFG_CYCLES   - full idle columns forced after the /T/ column
// Ports:
//   clock        - single clock
//   areset       - asynchronous active-high reset
//   saxis_tdata  - frame bytes, lane 0 = [7:0] = first on the wire
//   saxis_tkeep  - contiguous byte enables, partial only on the tlast beat
//   saxis_tvalid - beat valid
//   saxis_tready - beat accepted when tvalid && tready
//   saxis_tlast  - last beat of frame
//   saxis_tuser  - abort flag, sampled on the tlast beat
//   xgmii_d      - registered XGMII data, lane i = [8i+7:8i]
//   xgmii_c      - registered XGMII control, bit i = lane i
// Build option:
//   XG_MAC_TX_PAD_EN - zero-pad frames shorter than 60 bytes (pad is in the FCS)

module xg_mac_tx #(
    parameter int unsigned IFG_CYCLES = 1
) (
    input  logic        clock,
    input  logic        areset,
    input  logic [63:0] saxis_tdata,
    input  logic [7:0]  saxis_tkeep,
    input  logic        saxis_tvalid,
    output logic        saxis_tready,
    input  logic        saxis_tlast,
    input  logic        saxis_tuser,
    output logic [63:0] xgmii_d,
    output logic [7:0]  xgmii_c
);

    localparam logic [63:0] IDLE_D   = 64'h0707_0707_0707_0707;
    localparam logic [63:0] START_D  = 64'hD555_5555_5555_55FB;
    localparam logic [63:0] ABORT_D  = 64'h0707_0707_0707_FDFE;
    localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;

    typedef enum logic [2:0] {
        S_IDLE, S_PREAMBLE, S_DATA, S_TAIL, S_IFG, S_DROP, S_PAD
    } state_t;

    localparam state_t AFTER_T = (IFG_CYCLES == 0) ? S_IDLE : S_IFG;

    function automatic logic [31:0] crc_step(input logic [31:0] crc,
                                             input logic [63:0] data,
                                             input logic [7:0]  keep);
        logic [31:0] r;
        r = crc;
        for (int unsigned i = 0; i < 8; i++) begin
            if (keep[i]) begin
                r = r ^ {24'h0, data[8*i +: 8]};
                for (int unsigned j = 0; j < 8; j++)
                    r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
            end
        end
        return r;
    endfunction

    state_t       state, state_nxt;
    logic [31:0]  crc_q, crc_nxt, fcs;
    logic [63:0]  cur_data;
    logic [127:0] cur_wide;
    logic [7:0]   cur_keep;
    logic         cur_last, cur_err, pad_go;
    logic         beat_take, tail_load;
    logic [3:0]   n_bytes;
    logic [4:0]   t_pos;
    logic [127:0] end_d;
    logic [15:0]  end_c;
    logic [63:0]  col_d, tail_d;
    logic [7:0]   col_c, tail_c;
    logic [15:0]  ifg_cnt;
`ifdef XG_MAC_TX_PAD_EN
    logic [3:0]   beat_cnt;
    logic         err_q;
`endif

    // Beat presented to the CRC / column builder: the accepted AXI beat, or
    // a synthesized zero beat while padding.
    always_comb begin
        cur_data = '0;
        for (int unsigned i = 0; i < 8; i++)
            if (saxis_tkeep[i]) cur_data[8*i +: 8] = saxis_tdata[8*i +: 8];
        cur_keep = saxis_tkeep;
        cur_last = saxis_tlast;
        cur_err  = saxis_tuser;
        pad_go   = 1'b0;
`ifdef XG_MAC_TX_PAD_EN
        if (state == S_PAD) begin
            cur_data = '0;
            cur_last = (beat_cnt == 4'd7);
            cur_keep = cur_last ? 8'h0F : 8'hFF;
            cur_err  = err_q;
        end else if (state == S_DATA && saxis_tvalid && saxis_tlast && beat_cnt < 4'd7) begin
            cur_keep = 8'hFF;
            cur_last = 1'b0;
            pad_go   = 1'b1;
        end else if (state == S_DATA && saxis_tlast && beat_cnt == 4'd7 && !saxis_tkeep[3]) begin
            cur_keep = 8'h0F;
        end
`endif
    end

    assign cur_wide = {64'h0, cur_data};
    assign crc_nxt  = crc_step(crc_q, cur_data, cur_keep);
    assign fcs      = ~crc_nxt;

    // Two-column view of the frame end: data, FCS, optional /E/, /T/, /I/.
    // The upper column is held for TAIL when /T/ falls past lane 7.
    always_comb begin
        n_bytes = '0;
        for (int unsigned i = 0; i < 8; i++)
            n_bytes = n_bytes + 4'(cur_keep[i]);
        t_pos = 5'(n_bytes) + 5'd4 + 5'(cur_err);
        end_d = '0;
        end_c = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (i < 32'(n_bytes)) begin
                end_d[8*i +: 8] = cur_wide[8*i +: 8];
            end else if (i < 32'(n_bytes) + 32'd4) begin
                end_d[8*i +: 8] = fcs[8*(i - 32'(n_bytes)) +: 8];
            end else if (i < 32'(t_pos)) begin
                end_d[8*i +: 8] = 8'hFE;
                end_c[i]        = 1'b1;
            end else if (i == 32'(t_pos)) begin
                end_d[8*i +: 8] = 8'hFD;
                end_c[i]        = 1'b1;
            end else begin
                end_d[8*i +: 8] = 8'h07;
                end_c[i]        = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        col_d        = IDLE_D;
        col_c        = 8'hFF;
        saxis_tready = 1'b0;
        beat_take    = 1'b0;
        tail_load    = 1'b0;
        case (state)
            S_IDLE: if (saxis_tvalid) state_nxt = S_PREAMBLE;
            S_PREAMBLE: begin
                col_d     = START_D;
                col_c     = 8'h01;
                state_nxt = S_DATA;
            end
            S_DATA, S_PAD: begin
                saxis_tready = (state == S_DATA);
                if (state == S_DATA && !saxis_tvalid) begin
                    col_d     = ABORT_D;
                    col_c     = 8'hFF;
                    state_nxt = S_DROP;
                end else begin
                    beat_take = 1'b1;
                    if (cur_last) begin
                        col_d = end_d[63:0];
                        col_c = end_c[7:0];
                        if (t_pos >= 5'd8) begin
                            tail_load = 1'b1;
                            state_nxt = S_TAIL;
                        end else begin
                            state_nxt = AFTER_T;
                        end
                    end else begin
                        col_d = cur_data;
                        col_c = 8'h00;
                        if (pad_go) state_nxt = S_PAD;
                    end
                end
            end
            S_TAIL: begin
                col_d     = tail_d;
                col_c     = tail_c;
                state_nxt = AFTER_T;
            end
            S_IFG: if (32'(ifg_cnt) + 32'd1 >= IFG_CYCLES) state_nxt = S_IDLE;
            S_DROP: begin
                saxis_tready = 1'b1;
                if (saxis_tvalid && saxis_tlast) state_nxt = AFTER_T;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge areset) begin
        if (areset) begin
            state   <= S_IDLE;
            crc_q   <= '1;
            xgmii_d <= IDLE_D;
            xgmii_c <= '1;
            tail_d  <= IDLE_D;
            tail_c  <= '1;
            ifg_cnt <= '0;
        end else begin
            state   <= state_nxt;
            xgmii_d <= col_d;
            xgmii_c <= col_c;
            if (tail_load) begin
                tail_d <= end_d[127:64];
                tail_c <= end_c[15:8];
            end
            ifg_cnt <= (state == S_IFG) ? ifg_cnt + 16'd1 : '0;
            if (beat_take)
                crc_q <= cur_last ? '1 : crc_nxt;
            else if (state == S_IDLE)
                crc_q <= '1;
        end
    end

`ifdef XG_MAC_TX_PAD_EN
    always_ff @(posedge clock or posedge areset) begin
        if (areset) begin
            beat_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state == S_IDLE)
                beat_cnt <= '0;
            else if (beat_take && beat_cnt != 4'd8)
                beat_cnt <= beat_cnt + 4'd1;
            if (pad_go) err_q <= saxis_tuser;
        end
    end
`endif

endmodule

// File: tb/tb_xg_mac_tx.sv
// tb_xg_mac_tx: directed bench for xg_mac_tx (default build, IFG_CYCLES=1).
// Captures every XGMII column, then matches each frame's columns against a
// byte-serial model of the expected wire image plus hand-computed columns.

`timescale 1ns/1ps

module tb_xg_mac_tx;

    localparam int          IFG       = 1;
    localparam logic [71:0] IDLE_COL  = {64'h0707_0707_0707_0707, 8'hFF};
    localparam logic [71:0] START_COL = {64'hD555_5555_5555_55FB, 8'h01};
    localparam logic [71:0] UNDER_COL = {64'h0707_0707_0707_FDFE, 8'hFF};

    logic        clock = 1'b0;
    logic        areset;
    logic [63:0] saxis_tdata;
    logic [7:0]  saxis_tkeep;
    logic        saxis_tvalid;
    logic        saxis_tready;
    logic        saxis_tlast;
    logic        saxis_tuser;
    logic [63:0] xgmii_d;
    logic [7:0]  xgmii_c;

    int n_vec = 0;
    int n_err = 0;
    logic        cap = 1'b0;
    logic [71:0] cols[$];
    logic [71:0] exp_all[$];
    int          flen[$];

    xg_mac_tx #(.IFG_CYCLES(IFG)) dut (
        .clock        (clock),
        .areset       (areset),
        .saxis_tdata  (saxis_tdata),
        .saxis_tkeep  (saxis_tkeep),
        .saxis_tvalid (saxis_tvalid),
        .saxis_tready (saxis_tready),
        .saxis_tlast  (saxis_tlast),
        .saxis_tuser  (saxis_tuser),
        .xgmii_d      (xgmii_d),
        .xgmii_c      (xgmii_c)
    );

    always #5 clock = ~clock;

    always @(negedge clock) if (cap) cols.push_back({xgmii_d, xgmii_c});

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [71:0] col_at(input int idx);
        if (idx >= 0 && idx < cols.size()) return cols[idx];
        return 'x;
    endfunction

    function automatic logic [7:0] pbyte(input int pat, input int i);
        case (pat)
            0:       return 8'(i);
            1:       return 8'(i * 37 + 11);
            default: return 8'(8'h31 + i);
        endcase
    endfunction

    function automatic logic [31:0] crc32(input logic [7:0] b[$]);
        logic [31:0] c = 32'hFFFF_FFFF;
        foreach (b[i]) begin
            c = c ^ {24'h0, b[i]};
            for (int k = 0; k < 8; k++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic put_beat(input logic [63:0] d, input logic [7:0] k, input logic last, input logic user);
        saxis_tdata  = d;
        saxis_tkeep  = k;
        saxis_tlast  = last;
        saxis_tuser  = user;
        saxis_tvalid = 1'b1;
        for (int w = 0; w < 100 && saxis_tready !== 1'b1; w++) @(negedge clock);
        if (saxis_tready !== 1'b1) begin
            check("tready_wait", 72'(saxis_tready), 72'(1));
        end else begin
            @(negedge clock);
        end
    endtask

    // gap >= 0 drops tvalid for one cycle before beat 'gap'.
    task automatic send_frame(input int len, input int pat, input logic err, input int gap);
        logic [7:0]  b[$];
        logic [7:0]  wb[$];
        logic        wc[$];
        logic [31:0] c32;
        logic [63:0] d;
        logic [7:0]  c;
        int          fl;
        int          nb;
        for (int i = 0; i < len; i++) b.push_back(pbyte(pat, i));
        exp_all.push_back(START_COL);
        fl = 1;
        if (gap < 0) begin
            foreach (b[i]) begin wb.push_back(b[i]); wc.push_back(1'b0); end
            c32 = crc32(b);
            for (int k = 0; k < 4; k++) begin wb.push_back(c32[8*k +: 8]); wc.push_back(1'b0); end
            if (err) begin wb.push_back(8'hFE); wc.push_back(1'b1); end
            wb.push_back(8'hFD); wc.push_back(1'b1);
            while (wb.size() % 8 != 0) begin wb.push_back(8'h07); wc.push_back(1'b1); end
            for (int j = 0; j < wb.size() / 8; j++) begin
                for (int l = 0; l < 8; l++) begin
                    d[8*l +: 8] = wb[8*j + l];
                    c[l]        = wc[8*j + l];
                end
                exp_all.push_back({d, c});
                fl++;
            end
        end else begin
            for (int j = 0; j < gap; j++) begin
                for (int l = 0; l < 8; l++) d[8*l +: 8] = b[8*j + l];
                exp_all.push_back({d, 8'h00});
                fl++;
            end
            exp_all.push_back(UNDER_COL);
            fl++;
        end
        flen.push_back(fl);

        nb = (len + 7) / 8;
        for (int bt = 0; bt < nb; bt++) begin
            int n;
            if (bt == gap) begin
                saxis_tvalid = 1'b0;
                @(negedge clock);
            end
            n = (len - 8 * bt > 8) ? 8 : len - 8 * bt;
            d = '0;
            for (int l = 0; l < n; l++) d[8*l +: 8] = b[8*bt + l];
            put_beat(d, 8'((9'd1 << n) - 9'd1), bt == nb - 1, err && (bt == nb - 1));
        end
        saxis_tvalid = 1'b0;
        saxis_tlast  = 1'b0;
        saxis_tuser  = 1'b0;
    endtask

    int st[12];

    initial begin
        int cnt, ptr, base, s, s2, k;
        areset       = 1'b1;
        saxis_tdata  = '0;
        saxis_tkeep  = '0;
        saxis_tvalid = 1'b0;
        saxis_tlast  = 1'b0;
        saxis_tuser  = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_col", {xgmii_d, xgmii_c}, IDLE_COL);
        check("rst_tready", 72'(saxis_tready), 72'(0));
        areset = 1'b0;
        cap    = 1'b1;
        @(negedge clock);
        check("idle_col", {xgmii_d, xgmii_c}, IDLE_COL);

        // Reset in the middle of a frame.
        saxis_tdata  = 64'h1122_3344_5566_7788;
        saxis_tkeep  = 8'hFF;
        saxis_tvalid = 1'b1;
        for (int w = 0; w < 100 && saxis_tready !== 1'b1; w++) @(negedge clock);
        check("abort_tready", 72'(saxis_tready), 72'(1));
        repeat (2) @(negedge clock);
        areset = 1'b1;
        #1;
        check("abort_col", {xgmii_d, xgmii_c}, IDLE_COL);
        check("abort_tready0", 72'(saxis_tready), 72'(0));
        saxis_tvalid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        areset = 1'b0;
        cnt = 0;
        foreach (cols[i])
            for (int l = 0; l < 8; l++)
                if (cols[i][l] && cols[i][8 + 8*l +: 8] == 8'hFD) cnt++;
        check("abort_no_T", 72'(cnt), 72'(0));
        @(negedge clock);
        #1 cols.delete();
        @(negedge clock);

        send_frame(9,  2, 1'b0, -1);  // "123456789"
        send_frame(60, 1, 1'b0, -1);
        send_frame(64, 0, 1'b0, -1);
        send_frame(61, 1, 1'b0, -1);
        send_frame(62, 1, 1'b1, -1);
        send_frame(59, 0, 1'b1, -1);  // /E/ at lane 7, /T/ spills
        send_frame(40, 1, 1'b0, 2);   // underrun before beat 2
        send_frame(61, 0, 1'b0, -1);
        send_frame(57, 1, 1'b1, -1);
        send_frame(72, 0, 1'b0, -1);
        repeat (30) @(negedge clock);
        cap = 1'b0;

        ptr  = 0;
        base = 0;
        foreach (flen[f]) begin
            s = -1;
            for (int i = ptr; i < cols.size(); i++)
                if (s < 0 && cols[i] === START_COL) s = i;
            st[f] = s;
            check($sformatf("f%0d_start", f), col_at(s), START_COL);
            for (int j = 1; j < flen[f]; j++)
                check($sformatf("f%0d_col%0d", f, j), col_at(s + j), exp_all[base + j]);
            k = s + flen[f] - 1;
            check($sformatf("f%0d_ifg", f), col_at(k + 1), IDLE_COL);
            s2 = -1;
            for (int i = k + 1; i < cols.size(); i++)
                if (s2 < 0 && cols[i] === START_COL) s2 = i;
            if (s2 >= 0)
                check($sformatf("f%0d_gap", f), 72'((s2 - k) >= IFG + 1), 72'(1));
            if (s >= 0) ptr = k + 1;
            base += flen[f];
        end

        // Hand-computed columns: CRC-32("123456789") = CBF43926.
        check("h_123_data", col_at(st[0] + 1), {64'h3837_3635_3433_3231, 8'h00});
        check("h_123_fcs",  col_at(st[0] + 2), {64'h0707_FDCB_F439_2639, 8'hE0});
        check("h_60_T",     col_at(st[1] + 9), {64'h0707_0707_0707_07FD, 8'hFF});
        check("h_59e_T",    col_at(st[5] + 9), {64'h0707_0707_0707_07FD, 8'hFF});
        check("h_under",    col_at(st[6] + 3), UNDER_COL);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
